// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: whole-burst grants, round-robin on ties.
// Define AXI_ARB_DISPLAY_PRIORITY_EN to give master 1 fixed priority.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_arvalid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [7:0]            m0_arlen,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m0_rready,
  input  logic                  m1_arvalid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [7:0]            m1_arlen,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic                  m1_rready,
  output logic                  s_arvalid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [7:0]            s_arlen,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state;
  logic       grant;
  logic       last_grant;
  logic [7:0] beat_count;
  logic [7:0] burst_len;

  logic in_addr, in_data;
  logic winner;
  logic g_arvalid, g_rready;
  logic ar_hs, beat;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  always_comb begin
    winner = m1_arvalid;
`ifdef AXI_ARB_DISPLAY_PRIORITY_EN
    winner = m1_arvalid;
`else
    if (m0_arvalid && m1_arvalid)
      winner = ~last_grant;
`endif
  end

  assign g_arvalid = grant ? m1_arvalid : m0_arvalid;
  assign g_rready  = grant ? m1_rready  : m0_rready;

  assign s_arvalid = in_addr && g_arvalid;
  assign s_araddr  = in_addr ? (grant ? m1_araddr : m0_araddr)
                             : '0;
  assign s_arlen   = in_addr ? (grant ? m1_arlen : m0_arlen)
                             : '0;

  assign m0_arready = in_addr && !grant && s_arready;
  assign m1_arready = in_addr &&  grant && s_arready;

  // Data path is a pure pass-through; only the valid/ready are steered.
  assign s_rready  = in_data && g_rready;
  assign m0_rvalid = in_data && !grant && s_rvalid;
  assign m1_rvalid = in_data &&  grant && s_rvalid;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  assign ar_hs = s_arvalid && s_arready;
  assign beat  = in_data && s_rvalid && s_rready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_count <= 8'd0;
      burst_len  <= 8'd0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (m0_arvalid || m1_arvalid) begin
            grant <= winner;
            state <= ADDR;
          end
        end
        in_addr: begin
          if (ar_hs) begin
            burst_len  <= s_arlen;
            beat_count <= 8'd0;
            state      <= DATA;
          end
        end
        in_data: begin
          if (beat) begin
            beat_count <= beat_count + 8'd1;
            if (beat_count == burst_len) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: single burst, ties, backpressure,
// late arready and reset mid-burst, checked with immediate assertions.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_arvalid, m1_arvalid;
  logic [31:0] m0_araddr, m1_araddr;
  logic [7:0]  m0_arlen, m1_arlen;
  logic        m0_arready, m1_arready;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rready, m1_rready;
  logic        s_arvalid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic        s_rready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr),
    .m1_arlen(m1_arlen), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_rready(m1_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_s_arvalid"}, 32'(s_arvalid), 32'd0);
    chk({tag, "_s_araddr"}, s_araddr, 32'd0);
    chk({tag, "_s_arlen"}, 32'(s_arlen), 32'd0);
    chk({tag, "_s_rready"}, 32'(s_rready), 32'd0);
    chk({tag, "_m0_arready"}, 32'(m0_arready), 32'd0);
    chk({tag, "_m1_arready"}, 32'(m1_arready), 32'd0);
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
  endtask

  logic exp_g [4];

  initial begin
`ifdef AXI_ARB_DISPLAY_PRIORITY_EN
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    reset_n = 1'b0;
    m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0;
    tick(); tick();
    @(negedge clk);
    all_zero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // Single master burst, 4 beats
    m0_arvalid = 1; m0_araddr = 32'h1000; m0_arlen = 8'd3;
    @(negedge clk);
    chk("s1_idle_arvalid", 32'(s_arvalid), 32'd0);
    tick();
    s_arready = 1;
    @(negedge clk);
    chk("s1_arvalid", 32'(s_arvalid), 32'd1);
    chk("s1_araddr", s_araddr, 32'h1000);
    chk("s1_arlen", 32'(s_arlen), 32'd3);
    chk("s1_m0_arready", 32'(m0_arready), 32'd1);
    chk("s1_m1_arready", 32'(m1_arready), 32'd0);
    tick();
    m0_arvalid = 0; s_arready = 0; m0_rready = 1; s_rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'hD000 + 32'(i);
      @(negedge clk);
      chk("s1_m0_rvalid", 32'(m0_rvalid), 32'd1);
      chk("s1_m0_rdata", m0_rdata, 32'hD000 + 32'(i));
      chk("s1_m1_rvalid", 32'(m1_rvalid), 32'd0);
      chk("s1_s_rready", 32'(s_rready), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("s1_after_rvalid", 32'(m0_rvalid), 32'd0);
    chk("s1_after_rready", 32'(s_rready), 32'd0);
    tick();
    s_rvalid = 0;
    tick();

    // Tie: both request continuously with single-beat bursts
    m0_arvalid = 1; m0_araddr = 32'hA0; m0_arlen = 0;
    m1_arvalid = 1; m1_araddr = 32'hB0; m1_arlen = 0;
    m0_rready = 1; m1_rready = 1; s_arready = 1; s_rvalid = 1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("tie_dead", 32'(s_arvalid), 32'd0);
      tick();
      @(negedge clk);
      chk("tie_addr", s_araddr, exp_g[b] ? 32'hB0 : 32'hA0);
      tick();
      @(negedge clk);
      chk("tie_m0_rvalid", 32'(m0_rvalid), 32'(!exp_g[b]));
      chk("tie_m1_rvalid", 32'(m1_rvalid), 32'(exp_g[b]));
      tick();
    end
    // m1 steps back: m0 takes the next IDLE
    m1_arvalid = 0;
    tick();
    @(negedge clk);
    chk("tie_m0_after", s_araddr, 32'hA0);
    tick(); tick();
    m0_arvalid = 0; s_rvalid = 0; s_arready = 0;
    tick();

    // Backpressure on m1, 8 beats
    m1_arvalid = 1; m1_araddr = 32'h2000; m1_arlen = 8'd7;
    tick();
    s_arready = 1;
    @(negedge clk);
    chk("bp_m1_arready", 32'(m1_arready), 32'd1);
    chk("bp_m0_arready", 32'(m0_arready), 32'd0);
    tick();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      s_rdata = 32'(i);
      @(negedge clk);
      chk("bp_data", m1_rdata, 32'(i));
      tick();
    end
    s_rdata = 32'd3; m1_rready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stall_rready", 32'(s_rready), 32'd0);
      chk("bp_stall_rvalid", 32'(m1_rvalid), 32'd1);
      tick();
    end
    m1_rready = 1;
    for (int i = 3; i < 8; i++) begin
      s_rdata = 32'(i);
      @(negedge clk);
      chk("bp_in_data", 32'(s_rready), 32'd1);
      chk("bp_m0_rvalid", 32'(m0_rvalid), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("bp_done", 32'(s_rready), 32'd0);
    tick();
    s_rvalid = 0;
    tick();

    // Late arready, m1 queued behind m0
    m0_arvalid = 1; m0_araddr = 32'h3000; m0_arlen = 8'd1;
    tick();
    m1_arvalid = 1; m1_araddr = 32'h4000; m1_arlen = 8'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("late_arvalid", 32'(s_arvalid), 32'd1);
      chk("late_araddr", s_araddr, 32'h3000);
      chk("late_arlen", 32'(s_arlen), 32'd1);
      chk("late_m0_arready", 32'(m0_arready), 32'd0);
      tick();
    end
    s_arready = 1;
    @(negedge clk);
    chk("late_m0_go", 32'(m0_arready), 32'd1);
    chk("late_m1_no", 32'(m1_arready), 32'd0);
    tick();
    m0_arvalid = 0; s_arready = 0; s_rvalid = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("late_m0_rvalid", 32'(m0_rvalid), 32'd1);
      chk("late_m1_rvalid", 32'(m1_rvalid), 32'd0);
      tick();
    end
    s_rvalid = 0;
    @(negedge clk);
    chk("late_idle", 32'(s_arvalid), 32'd0);
    tick();
    @(negedge clk);
    chk("late_m1_addr", s_araddr, 32'h4000);
    s_arready = 1;
    tick();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1;
    tick();
    s_rvalid = 0;
    tick();

    // Reset during a 16-beat burst
    m0_arvalid = 1; m0_araddr = 32'h5000; m0_arlen = 8'd15;
    tick();
    s_arready = 1;
    tick();
    s_arready = 0; s_rvalid = 1;
    tick(); tick();
    @(negedge clk);
    chk("rst_pre_rvalid", 32'(m0_rvalid), 32'd1);
    reset_n = 0;
    #1;
    all_zero("rst_mid");
    tick();
    reset_n = 1;
    s_rvalid = 0;
    m0_araddr = 32'h6000; m0_arlen = 8'd1;
    tick();
    s_arready = 1;
    @(negedge clk);
    chk("rst_new_addr", s_araddr, 32'h6000);
    chk("rst_new_arready", 32'(m0_arready), 32'd1);
    tick();
    m0_arvalid = 0; s_arready = 0; s_rvalid = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_new_beat", 32'(m0_rvalid), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("rst_new_done", 32'(m0_rvalid), 32'd0);
    tick();
    s_rvalid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
